axis_cmd_fifo: RTL and testbench
================================

Name: axis_cmd_fifo

Overview:
- Elastic buffer on the 32-bit AXI Stream command path. It sits between the SPI-to-AXIS deserializer (upstream) and the rasterizer command input (downstream).
- It absorbs bursts from the host while the rasterizer is busy. It also produces a registered clear-to-send level indicator that the top level routes to the host flow-control pin.
- Storage is a single-clock RAM with registered read, so it maps to iCE40 EBR. A two-entry output stage gives first-word-fall-through at full throughput.

Parameters:
- DATA_WIDTH, 32, tdata width; tlast is stored alongside each word as an extra bit.
- ADDR_WIDTH, 4, RAM depth DEPTH = 2**ADDR_WIDTH words. Legal range is 2..10.
- CTS_THRESHOLD, 12, cts deasserts when stored words reach this level. Legal range is 1..DEPTH.

Ports:
- aclk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  synchronous discard of all contents
- s_axis_tvalid  in  1  upstream word valid
- s_axis_tready  out  1  FIFO can accept a word
- s_axis_tlast  in  1  last word of a command packet
- s_axis_tdata  in  DATA_WIDTH  upstream word
- m_axis_tvalid  out  1  output word valid
- m_axis_tready  in  1  downstream accepts
- m_axis_tlast  out  1  tlast of the output word
- m_axis_tdata  out  DATA_WIDTH  output word
- cts  out  1  registered clear-to-send; high = host may keep sending
- level  out  ADDR_WIDTH+1  words held (RAM plus output stage)

Behaviour:
- Reset values: resetn low clears every register asynchronously.
  - Pointers, counts, output stage and m_axis_tvalid all go to 0.
  - s_axis_tready=0, cts=0, level=0.
  - Outputs reach their operating values on the first aclk edge after resetn deasserts: s_axis_tready=1, cts=1.
- Handshakes (AXI Stream rules):
  - An upstream transfer happens on an edge where s_axis_tvalid and s_axis_tready are both high.
  - A downstream transfer happens on an edge where m_axis_tvalid and m_axis_tready are both high.
  - m_axis_tvalid, tdata and tlast stay stable while tvalid is high and tready is low.
  - m_axis_tvalid never depends combinationally on m_axis_tready.
- Capacity: DEPTH RAM words plus 2 output-stage words.
  - s_axis_tready is registered and is high iff RAM occupancy after this edge is < DEPTH.
  - No word is ever dropped or duplicated.
- Latency:
  - A word accepted into an empty FIFO on edge N is presented on m_axis_* after edge N+2.
  - With m_axis_tready held high and a continuous input, throughput is 1 word/cycle.
- Order: strict FIFO order; tlast travels with its word unchanged.
- Output stage: two registers, prefetch and output.
  - A RAM read is issued whenever the prefetch slot will be free after this edge.
  - The prefetch slot refills the output register in the same edge the output register is consumed.
- level: registered. Equals RAM occupancy plus the number of valid output-stage entries, and is updated every edge. Maximum value is DEPTH+2.
- cts: registered.
  - cts = (level_next < CTS_THRESHOLD).
  - Falls on the same edge that the threshold-crossing word is accepted.
  - Rises on the edge where level_next drops below the threshold.
- Pointers: ADDR_WIDTH-bit write and read pointers that wrap modulo DEPTH. The separate occupancy counter disambiguates full from empty.
- Simultaneous events:
  - Read and write on the same edge leave RAM occupancy unchanged.
  - A write when full is impossible, because tready is low.
  - A read when empty is not issued.
- flush (sampled high on an edge):
  - Pointers, occupancy and output stage clear.
  - After that edge m_axis_tvalid=0 and level=0.
  - s_axis_tready is forced low in the flush cycle, so no word is accepted. It returns high on the next edge.
  - Flush takes priority over any concurrent transfer.
  - cts=1 after the flush edge.
- Reset mid-operation: all contents are lost and all outputs take their reset values immediately, without waiting for an edge.

Decomposition:
- Shared package: the DATA_WIDTH default (the command stream width, 32) and a localparam DEPTH = 2**ADDR_WIDTH helper. No typedefs are needed.
- Sub-module: axis_fifo_ram, a simple dual-port RAM with one write port and one registered read port, sized (DATA_WIDTH+1) x DEPTH and written so yosys infers EBR.
- Pointer, occupancy, output-stage and cts logic stay in axis_cmd_fifo.

Test Plan:
- Single word: after reset, send 0xDEADBEEF with tlast=1 and m_axis_tready=1. Expect m_axis_tvalid high exactly 2 cycles after acceptance, tdata=0xDEADBEEF, tlast=1, level returning to 0.
- Fill to full: m_axis_tready=0, drive 20 words 0..19 with tvalid held.
  - Expect 18 words accepted (16 RAM + 2 stage), then s_axis_tready=0 and level=18.
  - Expect cts=0 from the edge accepting the 12th word.
- Drain: from full, raise m_axis_tready. Expect words 0..17 in order at 1 per cycle, cts back to 1 once level<12, and s_axis_tready high the cycle after the first read.
- Backpressure streaming: random tvalid and tready (50%) across 1000 words with tlast every 7th word. Scoreboard requires identical order and tlast, and no stall while both sides are ready.
- Flush: load 10 words and pulse flush for 1 cycle with s_axis_tvalid high. Expect no acceptance in that cycle, m_axis_tvalid=0 and level=0 after the edge, and the next word out is the first one sent after the flush.
- Async reset: assert resetn low between edges while holding 5 words. Expect m_axis_tvalid, s_axis_tready, cts and level at 0 immediately, and a subsequent word to pass with the normal 2-cycle latency.

Source files
------------

// File: rtl/axis_cmd_fifo_pkg.sv
// axis_cmd_fifo_pkg: shared widths and sizing helper for the command-path FIFO
package axis_cmd_fifo_pkg;
  localparam int CMD_DATA_WIDTH = 32;
  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/axis_fifo_ram.sv
// axis_fifo_ram: simple dual-port RAM with registered read, shaped for EBR inference
module axis_fifo_ram #(
  parameter int WIDTH = 33,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [WIDTH-1:0]      wd,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [WIDTH-1:0]      rd
);
  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];
  // write port plus read port whose output holds until the next enabled read
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end
endmodule

// File: rtl/axis_cmd_fifo.sv
// axis_cmd_fifo: EBR-backed AXIS command FIFO with FWFT output stage and registered cts
module axis_cmd_fifo
  import axis_cmd_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = CMD_DATA_WIDTH,
  parameter int ADDR_WIDTH = 4,
  parameter int CTS_THRESHOLD = 12
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  cts,
  output logic [ADDR_WIDTH:0]   level
);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int LW = ADDR_WIDTH + 1;
  localparam int W = DATA_WIDTH + 1;
  logic [ADDR_WIDTH-1:0] wp, rp;
  logic [LW-1:0] occ, occ_next, level_next;
  logic pv, ov, pv_next, ov_next, rdy, wr, rd, pop, o_load;
  logic [W-1:0] rd_data, o_q;
  // the RAM read register doubles as the prefetch slot; pv marks it valid
  axis_fifo_ram #(.WIDTH(W), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk(aclk),
    .we(wr),
    .wa(wp),
    .wd({s_axis_tlast, s_axis_tdata}),
    .re(rd),
    .ra(rp),
    .rd(rd_data)
  );
  assign s_axis_tready = rdy & ~flush;
  assign m_axis_tvalid = ov;
  assign {m_axis_tlast, m_axis_tdata} = o_q;
  // handshakes, prefetch refill and next occupancy/level
  always_comb begin
    wr = s_axis_tvalid & s_axis_tready;
    pop = ov & m_axis_tready;
    o_load = pv & (~ov | pop);
    rd = (occ != '0) & (~pv | o_load);
    pv_next = rd | (pv & ~o_load);
    ov_next = o_load | (ov & ~pop);
    occ_next = occ + LW'(wr) - LW'(rd);
    level_next = occ_next + LW'(pv_next) + LW'(ov_next);
  end
  // pointers, occupancy, output stage and registered flow-control outputs
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
      occ <= '0;
      pv <= 1'b0;
      ov <= 1'b0;
      o_q <= '0;
      rdy <= 1'b0;
      cts <= 1'b0;
      level <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      occ <= '0;
      pv <= 1'b0;
      ov <= 1'b0;
      o_q <= '0;
      rdy <= 1'b1;
      cts <= 1'b1;
      level <= '0;
    end else begin
      if (wr) wp <= wp + ADDR_WIDTH'(1);
      if (rd) rp <= rp + ADDR_WIDTH'(1);
      if (o_load) o_q <= rd_data;
      occ <= occ_next;
      pv <= pv_next;
      ov <= ov_next;
      rdy <= occ_next < LW'(DEPTH);
      cts <= level_next < LW'(CTS_THRESHOLD);
      level <= level_next;
    end
  end
endmodule

// File: tb/tb_axis_cmd_fifo.sv
// tb_axis_cmd_fifo: directed and randomized scoreboard bench for axis_cmd_fifo
module tb_axis_cmd_fifo;
  logic aclk = 1'b0, resetn = 1'b1, flush = 1'b0;
  logic s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b0;
  logic [31:0] s_tdata = '0;
  logic s_tready, m_tvalid, m_tlast, cts;
  logic [31:0] m_tdata;
  logic [4:0] level;
  logic [32:0] sb[$];
  logic [32:0] e;
  int checks = 0, errors = 0, pop_cnt = 0, cyc = 0;
  bit acc_last = 0, pop_last = 0;

  axis_cmd_fifo dut (
    .aclk(aclk), .resetn(resetn), .flush(flush),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tdata(s_tdata),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tdata(m_tdata),
    .cts(cts), .level(level)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task tick();
    #1;
    acc_last = s_tvalid && s_tready;
    pop_last = m_tvalid && m_tready;
    if (acc_last) sb.push_back({s_tlast, s_tdata});
    if (pop_last) begin
      pop_cnt++;
      chk("sb_nonempty_on_pop", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_word", {m_tlast, m_tdata}, e);
      end
    end
    @(posedge aclk);
    @(negedge aclk);
    cyc++;
  endtask

  initial begin
    int idx, start, sent, fa, la, fp, lp;
    bit hold;
    #2 resetn = 1'b0;
    #1;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_cts", cts, 0);
    chk("rst_level", level, 0);
    @(negedge aclk);
    resetn = 1'b1;
    #1 chk("tready_before_edge", s_tready, 0);
    @(negedge aclk);
    chk("tready_after_rst", s_tready, 1);
    chk("cts_after_rst", cts, 1);

    // single word latency
    s_tvalid = 1; s_tdata = 32'hDEADBEEF; s_tlast = 1; m_tready = 1;
    tick();
    s_tvalid = 0;
    chk("single_acc", acc_last, 1);
    chk("single_n0_valid", m_tvalid, 0);
    chk("single_n0_level", level, 1);
    tick();
    chk("single_n1_valid", m_tvalid, 0);
    chk("single_n1_level", level, 1);
    tick();
    chk("single_n2_valid", m_tvalid, 1);
    chk("single_n2_data", m_tdata, 32'hDEADBEEF);
    chk("single_n2_last", m_tlast, 1);
    tick();
    chk("single_level_done", level, 0);
    chk("single_valid_done", m_tvalid, 0);

    // fill to full
    m_tready = 0; idx = 0;
    for (int c = 0; c < 30 && idx < 20; c++) begin
      s_tvalid = 1; s_tdata = idx; s_tlast = 0;
      tick();
      if (acc_last) begin
        idx++;
        if (idx == 11) chk("cts_word11", cts, 1);
        if (idx == 12) chk("cts_word12", cts, 0);
      end
    end
    s_tvalid = 0;
    chk("fill_count", idx, 18);
    chk("full_tready", s_tready, 0);
    chk("full_level", level, 18);
    chk("full_cts", cts, 0);

    // drain
    m_tready = 1; pop_cnt = 0; start = cyc;
    tick();
    chk("tready_after_first_read", s_tready, 1);
    for (int c = 0; c < 40 && pop_cnt < 18; c++) begin
      chk("cts_vs_level", cts, level < 12);
      tick();
    end
    chk("drain_cycles", cyc - start, 18);
    chk("drain_pops", pop_cnt, 18);
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_level", level, 0);
    chk("drain_cts", cts, 1);

    // continuous streaming throughput and latency
    sent = 0; pop_cnt = 0; fa = -1; la = 0; fp = -1; lp = 0;
    for (int c = 0; c < 60; c++) begin
      s_tvalid = sent < 40; s_tdata = 100 + sent; s_tlast = (sent % 7) == 6;
      tick();
      if (acc_last) begin sent++; if (fa < 0) fa = c; la = c; end
      if (pop_last) begin if (fp < 0) fp = c; lp = c; end
    end
    s_tvalid = 0;
    chk("cont_acc_span", la - fa, 39);
    chk("cont_pop_span", lp - fp, 39);
    chk("cont_latency", fp - fa, 3);
    chk("cont_pops", pop_cnt, 40);

    // random backpressure
    sent = 0; pop_cnt = 0; hold = 0;
    for (int c = 0; c < 20000 && pop_cnt < 1000; c++) begin
      if (!hold) begin
        s_tvalid = (sent < 1000) && ($urandom_range(1) == 1);
        s_tdata = $urandom;
        s_tlast = (sent % 7) == 6;
      end
      m_tready = $urandom_range(1) == 1;
      tick();
      if (acc_last) sent++;
      hold = s_tvalid && !acc_last;
    end
    s_tvalid = 0; m_tready = 0;
    chk("rand_pops", pop_cnt, 1000);
    chk("rand_sb_empty", sb.size(), 0);

    // flush
    for (int i = 0; i < 10; i++) begin
      s_tvalid = 1; s_tdata = 32'hA000 + i; s_tlast = 0;
      tick();
    end
    chk("flush_preload", level, 10);
    flush = 1; s_tdata = 32'hF00D;
    #1 chk("flush_tready", s_tready, 0);
    tick();
    chk("flush_no_acc", acc_last, 0);
    sb.delete();
    flush = 0; s_tvalid = 0;
    chk("flush_valid", m_tvalid, 0);
    chk("flush_level", level, 0);
    chk("flush_cts", cts, 1);
    tick();
    chk("flush_tready_back", s_tready, 1);
    s_tvalid = 1; s_tdata = 32'hCAFE0001; s_tlast = 1; m_tready = 1; pop_cnt = 0;
    tick();
    s_tvalid = 0;
    for (int c = 0; c < 10 && pop_cnt < 1; c++) tick();
    chk("flush_next_out", pop_cnt, 1);

    // async reset mid-operation
    m_tready = 0;
    for (int i = 0; i < 5; i++) begin
      s_tvalid = 1; s_tdata = 32'hB000 + i; s_tlast = 0;
      tick();
    end
    s_tvalid = 0;
    #2 resetn = 0;
    #1;
    chk("arst_m_tvalid", m_tvalid, 0);
    chk("arst_s_tready", s_tready, 0);
    chk("arst_cts", cts, 0);
    chk("arst_level", level, 0);
    sb.delete();
    @(negedge aclk);
    resetn = 1;
    tick();
    s_tvalid = 1; s_tdata = 32'h12345678; s_tlast = 0;
    tick();
    s_tvalid = 0;
    chk("arst_acc", acc_last, 1);
    chk("arst_n0_valid", m_tvalid, 0);
    tick();
    chk("arst_n1_valid", m_tvalid, 0);
    tick();
    chk("arst_n2_valid", m_tvalid, 1);
    chk("arst_n2_data", m_tdata, 32'h12345678);
    m_tready = 1;
    tick();
    chk("arst_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
